button_conditioner: RTL

//  Input-side front end for the countdown timer: turns raw DE-board KEY/SW levels into clean,

---
 rtl/button_conditioner.sv | 126 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Input front end for the countdown timer: synchronise, debounce and edge-detect the KEY/SW
// levels, and derive a long-press event and a registered run/pause level.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter int CW                = 32
) (
    input  logic       cin,
    input  logic       rst,
    input  logic [1:0] button,
    input  logic       sw,
    output logic       reset_pulse,
    output logic       hold_pulse,
    output logic       pause_pulse,
    output logic       run,
    output logic       sw_level,
    output logic       sw_edge
);

    localparam int NUM_IN = 3;
    // Lanes 0/1 are active-low keys (idle high); lane 2 is the preset switch (idle low).
    localparam logic [NUM_IN-1:0] INIT = 3'b011;

    typedef enum logic [1:0] {IDLE, HELD, FIRED} hold_state_t;

    logic [NUM_IN-1:0]         raw;
    logic [NUM_IN-1:0]         sync1;
    logic [NUM_IN-1:0]         sync2;
    logic [NUM_IN-1:0]         acc;
    logic [NUM_IN-1:0][CW-1:0] cnt;
    logic [1:0]                btn_prev;
    logic [1:0]                press;
    logic                      release0;
    hold_state_t               hold_state;
    logic [CW-1:0]             hold_cnt;

    assign raw      = {sw, button};
    assign press    = btn_prev & ~acc[1:0];
    assign release0 = ~btn_prev[0] & acc[0];

    // Per-lane 2-flop synchroniser and stability counter.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            sync1 <= INIT;
            sync2 <= INIT;
            acc   <= INIT;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == acc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge detection one cycle after acceptance; sw_level doubles as the previous sw value.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            btn_prev    <= 2'b11;
            reset_pulse <= 1'b0;
            pause_pulse <= 1'b0;
            run         <= 1'b1;
            sw_level    <= 1'b0;
            sw_edge     <= 1'b0;
        end else begin
            btn_prev    <= acc[1:0];
            reset_pulse <= press[0];
            pause_pulse <= press[1];
            if (press[1]) run <= ~run;
            sw_level    <= acc[2];
            sw_edge     <= acc[2] ^ sw_level;
        end
    end

    // Held count is 1 on the press cycle, so the fire cycle is LONG_PRESS_CYCLES-1 after it.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            hold_state <= IDLE;
            hold_cnt   <= '0;
            hold_pulse <= 1'b0;
        end else begin
            hold_pulse <= 1'b0;
            case (hold_state)
                IDLE: begin
                    if (press[0]) begin
                        hold_cnt <= CW'(1);
                        if (LONG_PRESS_CYCLES <= 1) begin
                            hold_state <= FIRED;
                            hold_pulse <= 1'b1;
                        end else begin
                            hold_state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (release0) begin
                        hold_state <= IDLE;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                        if (hold_cnt == CW'(LONG_PRESS_CYCLES - 1)) begin
                            hold_state <= FIRED;
                            hold_pulse <= 1'b1;
                        end
                    end
                end
                FIRED: begin
                    if (release0) begin
                        hold_state <= IDLE;
                        hold_cnt   <= '0;
                    end
                end
                default: hold_state <= IDLE;
            endcase
        end
    end

endmodule
